// File: rtl/radix4_approx_seq_mult_pkg.sv
// rtl/radix4_approx_seq_mult_pkg.sv - shared types and helpers for the radix-4 sequential multiplier
package radix4_approx_seq_mult_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic neg;
      logic one;
      logic two;
   } booth_sel_t;

   function automatic int num_digits(input int width);
      return width / 2 + 1;
   endfunction

   // Window is {b[2i+1], b[2i], b[2i-1]}; digit = -2*w[2] + w[1] + w[0]
   function automatic booth_sel_t booth_encode(input logic [2:0] win);
      booth_sel_t sel;
      sel = '0;
      case (win)
         3'b001, 3'b010: sel.one = 1'b1;
         3'b011:         sel.two = 1'b1;
         3'b100:         begin sel.neg = 1'b1; sel.two = 1'b1; end
         3'b101, 3'b110: begin sel.neg = 1'b1; sel.one = 1'b1; end
         default:        sel = '0;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/radix4_approx_seq_mult_if.sv
// rtl/radix4_approx_seq_mult_if.sv - operand/product handshake bundle for the sequential multiplier
interface radix4_approx_seq_mult_if #(
   parameter int WIDTH = 16
);
   logic                   in_valid;
   logic                   in_ready;
   logic [WIDTH-1:0]       a;
   logic [WIDTH-1:0]       b;
   logic                   approx_en;
   logic                   out_valid;
   logic                   out_ready;
   logic [2*WIDTH-1:0]     p;
   logic                   busy;

   modport master (
      output in_valid, a, b, approx_en, out_ready,
      input  in_ready, out_valid, p, busy
   );

   modport slave (
      input  in_valid, a, b, approx_en, out_ready,
      output in_ready, out_valid, p, busy
   );
endinterface

// File: rtl/radix4_booth_pp_gen.sv
// rtl/radix4_booth_pp_gen.sv - combinational masked, shifted radix-4 Booth partial product
module radix4_booth_pp_gen
   import radix4_approx_seq_mult_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int APPROX_K = 8,
   parameter int IDX_W    = 4
) (
   input  logic [WIDTH-1:0]   a,
   input  logic [2:0]         win,
   input  logic [IDX_W-1:0]   idx,
   input  logic               approx_en,
   output logic [2*WIDTH-1:0] pp
);
   localparam int PW = 2 * WIDTH;
   localparam logic [PW-1:0] KEEP_MASK = {PW{1'b1}} << APPROX_K;

   booth_sel_t    sel;
   logic [PW-1:0] mag;
   logic [PW-1:0] shifted;
   logic [PW-1:0] signed_pp;

   always_comb begin
      sel = booth_encode(win);
      mag = '0;
      if (sel.one) begin
         mag = PW'(a);
      end else if (sel.two) begin
         mag = PW'(a) << 1;
      end
      shifted   = mag << {idx, 1'b0};
      // Two's complement negate after the shift keeps the result modulo 2^PW
      signed_pp = sel.neg ? (~shifted + 1'b1) : shifted;
      pp        = approx_en ? (signed_pp & KEEP_MASK) : signed_pp;
   end
endmodule

// File: rtl/radix4_approx_seq_mult.sv
// rtl/radix4_approx_seq_mult.sv - iterative radix-4 Booth multiplier, one digit per clock, exact/approximate mode
module radix4_approx_seq_mult
   import radix4_approx_seq_mult_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int APPROX_K = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   radix4_approx_seq_mult_if.slave     bus
);
   localparam int N     = num_digits(WIDTH);
   localparam int CNT_W = $clog2(N + 1);
   localparam int PW    = 2 * WIDTH;

   generate
      if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
         $error("radix4_approx_seq_mult: WIDTH must be even and >= 4");
      end
      if (APPROX_K < 0 || APPROX_K > PW) begin : g_bad_k
         $error("radix4_approx_seq_mult: APPROX_K must be in 0..2*WIDTH");
      end
   endgenerate

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH+2:0]   b_q;
   logic               approx_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [PW-1:0]      acc_q;
   logic [PW-1:0]      p_q;
   logic [PW-1:0]      pp;
   logic [PW-1:0]      acc_next;
   logic               last_digit;
   logic               accept;
   logic               in_ready;
   logic               out_valid;
   logic               busy;

   radix4_booth_pp_gen #(
      .WIDTH    (WIDTH),
      .APPROX_K (APPROX_K),
      .IDX_W    (CNT_W)
   ) u_pp_gen (
      .a         (a_q),
      .win       (b_q[2:0]),
      .idx       (cnt_q),
      .approx_en (approx_q),
      .pp        (pp)
   );

   assign acc_next   = acc_q + pp;
   assign last_digit = (cnt_q == CNT_W'(N - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      accept    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (bus.in_valid) begin
               accept  = 1'b1;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            busy = 1'b1;
            if (last_digit) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (bus.out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Multiplier is held with b[-1]=0 below and two zero bits above, and shifted
   // down one digit per cycle so the current window is always b_q[2:0].
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         approx_q <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= '0;
         p_q      <= '0;
      end else if (accept) begin
         a_q      <= bus.a;
         b_q      <= {2'b00, bus.b, 1'b0};
         approx_q <= bus.approx_en;
         cnt_q    <= '0;
         acc_q    <= '0;
      end else if (state_q == ST_BUSY) begin
         acc_q <= acc_next;
         cnt_q <= cnt_q + 1'b1;
         b_q   <= b_q >> 2;
         if (last_digit) begin
            p_q <= acc_next;
         end
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.busy      = busy;
   assign bus.p         = p_q;
endmodule
